// File: rtl/mc_req_arbiter_pkg.sv
// Shared encodings for the memory-controller request arbiter: requester ids,
// latched operation type and arbiter FSM states.
package mc_req_arbiter_pkg;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_TECH = 1'b1;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mc_arb_tag_fifo.sv
// In-order FIFO of 1-bit requester tags for outstanding MC reads.
// Push and pop in the same cycle leave occupancy unchanged, even when full.
module mc_arb_tag_fifo #(
  parameter int TAG_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

  logic          mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy are control.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mc_req_arbiter.sv
// Round-robin arbiter sharing one MC request port between host and tech engine,
// steering read returns via an in-order tag FIFO. Optional MC_ARB_PERF_CNT_EN adds counters.
module mc_req_arbiter
  import mc_req_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 512,
  parameter int MASK_W    = 64,
  parameter int TAG_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_rden,
  input  logic [1:0]          req_wren,
  input  logic [2*ADDR_W-1:0] req_rdaddr,
  input  logic [2*ADDR_W-1:0] req_wraddr,
  input  logic [2*DATA_W-1:0] req_wrdata,
  input  logic [2*MASK_W-1:0] req_wrmask,
  output logic [1:0]          req_rack,
  output logic [1:0]          req_wack,
  output logic [1:0]          req_rdvalid,
  output logic [DATA_W-1:0]   req_rddata,
  output logic                mc_rden,
  output logic                mc_wren,
  output logic [ADDR_W-1:0]   mc_rdaddr,
  output logic [ADDR_W-1:0]   mc_wraddr,
  output logic [DATA_W-1:0]   mc_wrdata,
  output logic [MASK_W-1:0]   mc_wrmask,
  input  logic                mc_rack,
  input  logic                mc_wack,
  input  logic [DATA_W-1:0]   mc_rddata,
  input  logic                mc_rdvalid,
  output logic                err_stray_rd
`ifdef MC_ARB_PERF_CNT_EN
  ,
  output logic [63:0]         perf_grant_rd,
  output logic [63:0]         perf_grant_wr,
  output logic [31:0]         perf_full_stall
`endif
);

  arb_state_t state, state_nxt;
  logic       grant_id;
  arb_op_t    grant_op;
  logic       rr_last;
  logic       grant_take;
  logic [1:0] elig;
  logic       pick;
  arb_op_t    pick_op;
  logic       tag_push, tag_pop, tag_dout, tag_full, tag_empty;

  assign elig = req_wren | (req_rden & {2{~tag_full}});

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    if (elig == 2'b11)        pick = ~rr_last;
    else if (elig[REQ_HOST])  pick = REQ_HOST;
    else                      pick = REQ_TECH;
    pick_op = req_wren[pick] ? OP_WR : OP_RD;
  end

  always_comb begin
    state_nxt  = state;
    grant_take = 1'b0;
    mc_rden    = 1'b0;
    mc_wren    = 1'b0;
    req_rack   = 2'b00;
    req_wack   = 2'b00;
    tag_push   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|elig) begin
          grant_take = 1'b1;
          state_nxt  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        mc_rden = (grant_op == OP_RD);
        mc_wren = (grant_op == OP_WR);
        if (grant_op == OP_RD && mc_rack) begin
          req_rack[grant_id] = 1'b1;
          tag_push           = 1'b1;
          state_nxt          = ARB_IDLE;
        end else if (grant_op == OP_WR && mc_wack) begin
          req_wack[grant_id] = 1'b1;
          state_nxt          = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    mc_rdaddr = '0;
    mc_wraddr = '0;
    mc_wrdata = '0;
    mc_wrmask = '0;
    if (state == ARB_BUSY) begin
      if (grant_id == REQ_TECH) begin
        mc_rdaddr = req_rdaddr[2*ADDR_W-1:ADDR_W];
        mc_wraddr = req_wraddr[2*ADDR_W-1:ADDR_W];
        mc_wrdata = req_wrdata[2*DATA_W-1:DATA_W];
        mc_wrmask = req_wrmask[2*MASK_W-1:MASK_W];
      end else begin
        mc_rdaddr = req_rdaddr[ADDR_W-1:0];
        mc_wraddr = req_wraddr[ADDR_W-1:0];
        mc_wrdata = req_wrdata[DATA_W-1:0];
        mc_wrmask = req_wrmask[MASK_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      grant_id     <= REQ_HOST;
      grant_op     <= OP_RD;
      rr_last      <= 1'b1;
      err_stray_rd <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_take) begin
        grant_id <= pick;
        grant_op <= pick_op;
        rr_last  <= pick;
      end
      if (mc_rdvalid && tag_empty) err_stray_rd <= 1'b1;
    end
  end

  // A return with no outstanding tag is dropped rather than steered.
  assign tag_pop     = mc_rdvalid && !tag_empty;
  assign req_rdvalid = tag_pop ? (tag_dout ? 2'b10 : 2'b01) : 2'b00;
  assign req_rddata  = mc_rddata;

  mc_arb_tag_fifo #(
    .TAG_DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tag_push),
    .pop  (tag_pop),
    .din  (grant_id),
    .dout (tag_dout),
    .full (tag_full),
    .empty(tag_empty)
  );

`ifdef MC_ARB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic stall_cond;
  assign stall_cond = (state == ARB_IDLE) && tag_full && |(req_rden & ~req_wren);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_rd   <= '0;
      perf_grant_wr   <= '0;
      perf_full_stall <= '0;
    end else begin
      if (grant_take && pick_op == OP_RD) begin
        if (pick) perf_grant_rd[63:32] <= sat_inc(perf_grant_rd[63:32]);
        else      perf_grant_rd[31:0]  <= sat_inc(perf_grant_rd[31:0]);
      end
      if (grant_take && pick_op == OP_WR) begin
        if (pick) perf_grant_wr[63:32] <= sat_inc(perf_grant_wr[63:32]);
        else      perf_grant_wr[31:0]  <= sat_inc(perf_grant_wr[31:0]);
      end
      if (stall_cond) perf_full_stall <= sat_inc(perf_full_stall);
    end
  end
`endif

endmodule

// File: tb/tb_mc_req_arbiter.sv
// Self-checking bench for mc_req_arbiter (default build); expected read-return
// steering is queued when reads are acked and compared when returns arrive.
module tb_mc_req_arbiter;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 512;
  localparam int MASK_W = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_rden, req_wren;
  logic [2*ADDR_W-1:0] req_rdaddr, req_wraddr;
  logic [2*DATA_W-1:0] req_wrdata;
  logic [2*MASK_W-1:0] req_wrmask;
  logic [1:0]          req_rack, req_wack, req_rdvalid;
  logic [DATA_W-1:0]   req_rddata;
  logic                mc_rden, mc_wren;
  logic [ADDR_W-1:0]   mc_rdaddr, mc_wraddr;
  logic [DATA_W-1:0]   mc_wrdata;
  logic [MASK_W-1:0]   mc_wrmask;
  logic                mc_rack, mc_wack, mc_rdvalid;
  logic [DATA_W-1:0]   mc_rddata;
  logic                err_stray_rd;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  mc_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req_rden(req_rden), .req_wren(req_wren),
    .req_rdaddr(req_rdaddr), .req_wraddr(req_wraddr),
    .req_wrdata(req_wrdata), .req_wrmask(req_wrmask),
    .req_rack(req_rack), .req_wack(req_wack),
    .req_rdvalid(req_rdvalid), .req_rddata(req_rddata),
    .mc_rden(mc_rden), .mc_wren(mc_wren),
    .mc_rdaddr(mc_rdaddr), .mc_wraddr(mc_wraddr),
    .mc_wrdata(mc_wrdata), .mc_wrmask(mc_wrmask),
    .mc_rack(mc_rack), .mc_wack(mc_wack),
    .mc_rddata(mc_rddata), .mc_rdvalid(mc_rdvalid),
    .err_stray_rd(err_stray_rd)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, leaving time just after the edge for driving inputs.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_rden = '0; req_wren = '0;
    req_rdaddr = '0; req_wraddr = '0; req_wrdata = '0; req_wrmask = '0;
    mc_rack = 1'b0; mc_wack = 1'b0; mc_rdvalid = 1'b0; mc_rddata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    adv();
    adv();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Drive one MC read return and compare the steering against the scoreboard.
  task automatic do_return(input string tag, input logic [63:0] data);
    logic [1:0] exp;
    mc_rdvalid = 1'b1;
    mc_rddata  = {8{data}};
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      exp = 2'b00;
    end else begin
      exp = exp_q.pop_front();
    end
    chk({tag, "_rdvalid"}, 64'(req_rdvalid), 64'(exp));
    chk({tag, "_rddata"}, req_rddata[63:0], data);
    adv();
    mc_rdvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Reset state
    #1;
    chk("rst_mc_rden", 64'(mc_rden), 64'd0);
    chk("rst_mc_wren", 64'(mc_wren), 64'd0);
    chk("rst_rack", 64'(req_rack), 64'd0);
    chk("rst_wack", 64'(req_wack), 64'd0);
    chk("rst_rdvalid", 64'(req_rdvalid), 64'd0);
    chk("rst_rdaddr", 64'(mc_rdaddr), 64'd0);
    chk("rst_err", 64'(err_stray_rd), 64'd0);

    // Single read with a three-cycle MC ack
    adv();
    req_rden = 2'b01;
    req_rdaddr[ADDR_W-1:0] = 30'h0000100;
    req_rdaddr[2*ADDR_W-1:ADDR_W] = 30'h0000777;
    #1;
    chk("sr_idle_rden", 64'(mc_rden), 64'd0);
    adv();
    chk("sr_busy_rden", 64'(mc_rden), 64'd1);
    chk("sr_rdaddr", 64'(mc_rdaddr), 64'h100);
    chk("sr_no_rack", 64'(req_rack), 64'd0);
    adv();
    adv();
    mc_rack = 1'b1;
    #1;
    chk("sr_held_rden", 64'(mc_rden), 64'd1);
    chk("sr_rack", 64'(req_rack), 64'b01);
    exp_q.push_back(2'b01);
    adv();
    mc_rack = 1'b0;
    req_rden = 2'b00;
    #1;
    chk("sr_back_idle", 64'(mc_rden), 64'd0);
    adv();
    do_return("sr_ret", 64'hDEAD_BEEF_0000_0001);

    // Tie round-robin with immediate acks
    do_reset();
    req_rden = 2'b11;
    req_rdaddr[ADDR_W-1:0] = 30'h0000AAA;
    req_rdaddr[2*ADDR_W-1:ADDR_W] = 30'h0000BBB;
    mc_rack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_idle_rack", 64'(req_rack), 64'd0);
      adv();
      chk("rr_rack", 64'(req_rack), (k % 2 == 0) ? 64'b01 : 64'b10);
      chk("rr_addr", 64'(mc_rdaddr), (k % 2 == 0) ? 64'hAAA : 64'hBBB);
      exp_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
      adv();
    end
    req_rden = 2'b00;
    mc_rack = 1'b0;
    adv();
    for (int k = 0; k < 4; k++) do_return("rr_ret", 64'h1000 + 64'(k));

    // Write wins over read on the same requester; routing from slice 1
    do_reset();
    req_wren = 2'b10;
    req_rden = 2'b10;
    req_wraddr[2*ADDR_W-1:ADDR_W] = 30'h0000055;
    req_wraddr[ADDR_W-1:0] = 30'h0000011;
    req_wrmask[2*MASK_W-1:MASK_W] = 64'hFF;
    req_wrmask[MASK_W-1:0] = 64'hFFFF_0000_0000_0000;
    req_wrdata[2*DATA_W-1:DATA_W] = {64{8'hA5}};
    req_wrdata[DATA_W-1:0] = {64{8'h3C}};
    #1;
    chk("wr_idle_wren", 64'(mc_wren), 64'd0);
    adv();
    mc_rack = 1'b1;
    #1;
    chk("wr_wren", 64'(mc_wren), 64'd1);
    chk("wr_rden", 64'(mc_rden), 64'd0);
    chk("wr_mask", mc_wrmask, 64'hFF);
    chk("wr_addr", 64'(mc_wraddr), 64'h55);
    chk("wr_data_lo", mc_wrdata[63:0], {8{8'hA5}});
    chk("wr_data_hi", mc_wrdata[DATA_W-1:DATA_W-64], {8{8'hA5}});
    chk("wr_mismatch_rack", 64'(req_rack), 64'd0);
    chk("wr_mismatch_wack", 64'(req_wack), 64'd0);
    adv();
    mc_rack = 1'b0;
    mc_wack = 1'b1;
    #1;
    chk("wr_still_busy", 64'(mc_wren), 64'd1);
    chk("wr_wack", 64'(req_wack), 64'b10);
    chk("wr_no_rack", 64'(req_rack), 64'd0);
    adv();
    clear_inputs();
    #1;
    chk("wr_done", 64'(mc_wren), 64'd0);

    // FIFO full: eight reads outstanding block the ninth, writes still flow
    do_reset();
    req_rden = 2'b01;
    mc_rack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_rdaddr[ADDR_W-1:0] = ADDR_W'(k + 16);
      adv();
      chk("ff_rack", 64'(req_rack), 64'b01);
      chk("ff_addr", 64'(mc_rdaddr), 64'(k + 16));
      exp_q.push_back(2'b01);
      adv();
    end
    for (int k = 0; k < 3; k++) begin
      adv();
      chk("ff_blocked_rden", 64'(mc_rden), 64'd0);
    end
    req_wren = 2'b10;
    req_wrmask[2*MASK_W-1:MASK_W] = 64'h0F;
    mc_wack = 1'b1;
    adv();
    chk("ff_wr_wren", 64'(mc_wren), 64'd1);
    chk("ff_wr_wack", 64'(req_wack), 64'b10);
    chk("ff_wr_rden", 64'(mc_rden), 64'd0);
    adv();
    req_wren = 2'b00;
    mc_wack = 1'b0;
    do_return("ff_free", 64'h5555);
    #1;
    chk("ff_n1_rden", 64'(mc_rden), 64'd0);
    adv();
    chk("ff_n2_rden", 64'(mc_rden), 64'd1);
    chk("ff_n2_rack", 64'(req_rack), 64'b01);
    exp_q.push_back(2'b01);
    adv();
    req_rden = 2'b00;
    mc_rack = 1'b0;
    adv();
    for (int k = 0; k < 8; k++) do_return("ff_drain", 64'h2000 + 64'(k));
    chk("ff_sb_left", 64'(exp_q.size()), 64'd0);
    chk("ff_no_err", 64'(err_stray_rd), 64'd0);

    // Stray return sets the sticky error
    do_reset();
    mc_rdvalid = 1'b1;
    #1;
    chk("st_rdvalid", 64'(req_rdvalid), 64'd0);
    adv();
    mc_rdvalid = 1'b0;
    #1;
    chk("st_err", 64'(err_stray_rd), 64'd1);
    adv();
    adv();
    chk("st_err_held", 64'(err_stray_rd), 64'd1);
    do_reset();
    #1;
    chk("st_err_clr", 64'(err_stray_rd), 64'd0);

    // Reset mid-grant discards the grant and outstanding tags
    req_rden = 2'b01;
    mc_rack = 1'b1;
    adv();
    chk("rm_pre_rack", 64'(req_rack), 64'b01);
    adv();
    req_rden = 2'b10;
    mc_rack = 1'b0;
    adv();
    chk("rm_busy", 64'(mc_rden), 64'd1);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    req_rden = 2'b00;
    #1;
    chk("rm_rden", 64'(mc_rden), 64'd0);
    mc_rdvalid = 1'b1;
    #1;
    chk("rm_fifo_empty", 64'(req_rdvalid), 64'd0);
    adv();
    mc_rdvalid = 1'b0;
    req_rden = 2'b11;
    mc_rack = 1'b1;
    adv();
    chk("rm_tie_rack", 64'(req_rack), 64'b01);
    adv();
    clear_inputs();
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_req_arbiter.md
Name: mc_req_arbiter

Overview:
- Shares the single memory-controller request port between two requesters.
  - Requester 0: host path (axi_to_mc arb_* side).
  - Requester 1: PiDRAM technique/command engine.
- Round-robin grant; holds each grant until the MC acknowledges it.
- Tracks outstanding reads in an in-order tag FIFO so each MC read return is steered to the requester that issued it.
- Sits between axi_to_mc / tech engine and the MC front end.

Parameters:
- ADDR_W, 30, request address width.
- DATA_W, 512, read/write data width.
- MASK_W, 64, write byte-mask width (DATA_W/8).
- TAG_DEPTH, 8, max outstanding reads; power of two, 2..32.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_rden  in  2  per-requester read request, bit i = requester i.
- req_wren  in  2  per-requester write request.
- req_rdaddr  in  2*ADDR_W  read addresses, slice i.
- req_wraddr  in  2*ADDR_W  write addresses, slice i.
- req_wrdata  in  2*DATA_W  write data, slice i.
- req_wrmask  in  2*MASK_W  write masks, slice i.
- req_rack  out  2  read accepted, one-hot.
- req_wack  out  2  write accepted, one-hot.
- req_rdvalid  out  2  read data valid for requester i, one-hot.
- req_rddata  out  DATA_W  read data, broadcast to both requesters.
- mc_rden  out  1  read request to MC.
- mc_wren  out  1  write request to MC.
- mc_rdaddr  out  ADDR_W  read address to MC.
- mc_wraddr  out  ADDR_W  write address to MC.
- mc_wrdata  out  DATA_W  write data to MC.
- mc_wrmask  out  MASK_W  write mask to MC.
- mc_rack  in  1  MC read accept.
- mc_wack  in  1  MC write accept.
- mc_rddata  in  DATA_W  MC read data.
- mc_rdvalid  in  1  MC read data valid, in issue order.
- err_stray_rd  out  1  sticky: read return arrived with no outstanding tag.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - State IDLE; tag FIFO empty; rr_last=1, so requester 0 wins the first tie.
  - err_stray_rd=0.
  - All mc_*en, req_rack, req_wack, req_rdvalid = 0; address/data outputs = 0.
- Eligibility:
  - Requester i is eligible if req_wren[i], or if req_rden[i] and the tag FIFO is not full.
- IDLE:
  - If any requester is eligible, pick one: the only eligible one, or on a tie the one != rr_last.
  - Latch grant id and op; write wins if both rden and wren are set.
  - Set rr_last = id and go to BUSY.
  - Nothing is driven to the MC in IDLE.
- BUSY:
  - Assert mc_rden or mc_wren from a registered op.
  - Address, data and mask are muxed from the granted requester's slices.
  - The requester must hold its request stable until acked. If it deasserts early, the grant is still held until the MC ack.
  - On mc_rack (op=read):
    - req_rack[id]=1 in the same cycle (combinational pass-through, gated by grant).
    - Push id into the tag FIFO.
    - Go to IDLE.
  - On mc_wack (op=write): req_wack[id]=1 in the same cycle; go to IDLE.
  - An MC ack that does not match the latched op is ignored.
- Latency:
  - Request seen in IDLE at cycle N → mc_*en asserted at N+1.
  - Minimum one idle bubble between consecutive grants.
  - Back-to-back throughput is one request per 2 cycles when the MC acks immediately.
- Read return:
  - mc_rdvalid pops the FIFO head h; req_rdvalid[h]=1 in the same cycle.
  - req_rddata = mc_rddata, always passed through.
- Boundary conditions:
  - Push and pop in the same cycle: occupancy unchanged; allowed even at full-1 or full.
  - FIFO full: reads are not granted; writes still proceed.
  - mc_rdvalid with FIFO empty: no req_rdvalid, data dropped, err_stray_rd set until reset.
  - Pointers wrap modulo TAG_DEPTH; occupancy counter is log2(TAG_DEPTH)+1 bits.
  - Reset during BUSY: grant abandoned and outstanding tags discarded. The system must quiesce the MC before reset.

Optional Feature:
- Macro MC_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_grant_rd and perf_grant_wr, each 2x32 bits, one counter per requester.
  - Adds perf_full_stall, 32 bits: counts cycles in IDLE with a pending read blocked only by a full FIFO.
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package/header (next to encoding.vh):
  - Requester id constants REQ_HOST=0, REQ_TECH=1.
  - Op encoding OP_RD=0, OP_WR=1.
  - State encoding ARB_IDLE, ARB_BUSY.
- One sub-module: mc_arb_tag_fifo.
  - 1-bit wide, TAG_DEPTH deep, synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty.
- Arbitration and muxing stay in the top module.

Test Plan:
- Single read: req_rden=2'b01, rdaddr0=0x0000100, MC acks 3 cycles later → mc_rden rises 1 cycle after the request, mc_rdaddr=0x0000100, req_rack=2'b01 on the ack cycle; one mc_rdvalid later → req_rdvalid=2'b01.
- Tie round-robin: both requesters hold req_rden continuously, MC acks immediately → grant order 0,1,0,1 with acks every 2 cycles; four returns are steered 01,10,01,10.
- Write priority and routing: req_wren=2'b10, wrmask1=64'hFF, wrdata1=512'hA5 repeated → mc_wren=1, mc_wrmask=0xFF, req_wack=2'b10 only.
- FIFO full: TAG_DEPTH=8, 8 reads issued with no returns → 9th read held with mc_rden=0; a concurrent write from the other requester is still granted; one mc_rdvalid then frees a slot → the read is granted 2 cycles later.
- Stray return: after reset, pulse mc_rdvalid → req_rdvalid=0 and err_stray_rd=1, held until rst.
- Reset mid-grant: assert rst during BUSY → next cycle mc_rden=0, FIFO empty, requester 0 wins the next tie.
